// File: rtl/video_pkg.sv
// Shared video timing constants and the sprite scheduler state type.
package video_pkg;

  localparam int unsigned POS_W     = 9;
  localparam int unsigned H_DISPLAY = 256;
  localparam int unsigned V_DISPLAY = 240;
  localparam int unsigned LOAD_HPOS = 260;
  localparam int unsigned SPRITE_H  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_V,
    WAIT_LOAD,
    WAIT_H,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sprite_pos_latch.sv
// Double-buffered sprite position: shadow regs written any time, copied to live at frame commit.
module sprite_pos_latch #(
  parameter int unsigned H_DISPLAY = video_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY = video_pkg::V_DISPLAY,
  parameter int unsigned SPRITE_H  = video_pkg::SPRITE_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_pos_wr,
  input  logic [video_pkg::POS_W-1:0] i_pos_x,
  input  logic [video_pkg::POS_W-1:0] i_pos_y,
  input  logic                       i_pos_en,
  input  logic                       i_commit,
  output logic [video_pkg::POS_W-1:0] o_x_l,
  output logic [video_pkg::POS_W-1:0] o_y_l,
  output logic                       o_valid,
  output logic                       o_valid_nxt
);
  import video_pkg::*;

  localparam logic [POS_W-1:0] XMAX = POS_W'(H_DISPLAY - SPRITE_H);
  localparam logic [POS_W-1:0] YMAX = POS_W'(V_DISPLAY - SPRITE_H - 1);

  logic [POS_W-1:0] r_sh_x, r_sh_y, r_x_l, r_y_l;
  logic             r_sh_en, r_en_l;
  logic [POS_W-1:0] w_x_clamp, w_x_nxt, w_y_nxt;
  logic             w_en_nxt;

  // A write landing on the commit cycle goes live directly.
  always_comb begin
    w_x_clamp = (i_pos_x > XMAX) ? XMAX : i_pos_x;
    w_x_nxt   = i_pos_wr ? w_x_clamp : r_sh_x;
    w_y_nxt   = i_pos_wr ? i_pos_y   : r_sh_y;
    w_en_nxt  = i_pos_wr ? i_pos_en  : r_sh_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_sh_en <= 1'b0;
    end else if (i_pos_wr) begin
      r_sh_x  <= w_x_clamp;
      r_sh_y  <= i_pos_y;
      r_sh_en <= i_pos_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_l  <= '0;
      r_y_l  <= '0;
      r_en_l <= 1'b0;
    end else if (i_commit) begin
      r_x_l  <= w_x_nxt;
      r_y_l  <= w_y_nxt;
      r_en_l <= w_en_nxt;
    end
  end

  assign o_x_l       = r_x_l;
  assign o_y_l       = r_y_l;
  assign o_valid     = r_en_l && (r_y_l <= YMAX);
  assign o_valid_nxt = w_en_nxt && (w_y_nxt <= YMAX);

endmodule

// File: rtl/sprite_scheduler.sv
// Beam-driven pulse sequencer: vstart, then 16 load/hstart pairs for one 16x16 sprite per frame.
module sprite_scheduler #(
  parameter int unsigned H_DISPLAY = video_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY = video_pkg::V_DISPLAY,
  parameter int unsigned LOAD_HPOS = video_pkg::LOAD_HPOS,
  parameter int unsigned SPRITE_H  = video_pkg::SPRITE_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [video_pkg::POS_W-1:0] hpos,
  input  logic [video_pkg::POS_W-1:0] vpos,
  input  logic                       pos_wr,
  input  logic [video_pkg::POS_W-1:0] pos_x,
  input  logic [video_pkg::POS_W-1:0] pos_y,
  input  logic                       pos_en,
  output logic                       vstart,
  output logic                       load,
  output logic                       hstart,
  output logic                       active,
  output logic                       frame_tick
);
  import video_pkg::*;

  sched_state_t     r_state, w_state_d;
  logic [3:0]       r_line_cnt, w_cnt_d;
  logic             r_vstart, r_load, r_hstart, r_active, r_frame_tick;
  logic             w_vstart_d, w_load_d, w_hstart_d, w_active_d;
  logic             w_boundary, w_valid, w_valid_nxt;
  logic [POS_W-1:0] w_x_l, w_y_l;

  assign w_boundary = (hpos == '0) && (vpos == POS_W'(V_DISPLAY));

  sprite_pos_latch #(
    .H_DISPLAY (H_DISPLAY),
    .V_DISPLAY (V_DISPLAY),
    .SPRITE_H  (SPRITE_H)
  ) u_pos_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pos_wr    (pos_wr),
    .i_pos_x     (pos_x),
    .i_pos_y     (pos_y),
    .i_pos_en    (pos_en),
    .i_commit    (w_boundary),
    .o_x_l       (w_x_l),
    .o_y_l       (w_y_l),
    .o_valid     (w_valid),
    .o_valid_nxt (w_valid_nxt)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_line_cnt;
    w_vstart_d = 1'b0;
    w_load_d   = 1'b0;
    w_hstart_d = 1'b0;
    w_active_d = r_active;
    // Every boundary restarts the schedule; in WAIT_* states this is an abort.
    if (w_boundary) begin
      w_cnt_d    = '0;
      w_active_d = 1'b0;
      w_state_d  = w_valid_nxt ? WAIT_V : IDLE;
    end else begin
      unique case (r_state)
        IDLE: ;
        WAIT_V: begin
          if (w_valid && (hpos == '0) && (vpos == w_y_l)) begin
            w_vstart_d = 1'b1;
            w_active_d = 1'b1;
            w_state_d  = WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (hpos == POS_W'(LOAD_HPOS)) begin
            w_load_d  = 1'b1;
            w_state_d = WAIT_H;
          end
        end
        WAIT_H: begin
          if (hpos == w_x_l) begin
            w_hstart_d = 1'b1;
            w_cnt_d    = r_line_cnt + 4'd1;
            w_state_d  = (r_line_cnt == 4'(SPRITE_H - 1)) ? DONE : WAIT_LOAD;
          end
        end
        // Dropping active here keeps it high through the last hstart pulse.
        DONE: w_active_d = 1'b0;
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_line_cnt   <= '0;
      r_vstart     <= 1'b0;
      r_load       <= 1'b0;
      r_hstart     <= 1'b0;
      r_active     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_line_cnt   <= w_cnt_d;
      r_vstart     <= w_vstart_d;
      r_load       <= w_load_d;
      r_hstart     <= w_hstart_d;
      r_active     <= w_active_d;
      r_frame_tick <= w_boundary;
    end
  end

  assign vstart     = r_vstart;
  assign load       = r_load;
  assign hstart     = r_hstart;
  assign active     = r_active;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Frame-level bench for sprite_scheduler: expected pulse events queued per frame, matched as seen.
module tb_sprite_scheduler;

  localparam int H_TOTAL  = 262;
  localparam int SHORT_LN = 2;
  localparam int V_LAST   = 240;
  localparam int LD_SEEN  = 261;

  localparam int EV_VST = 0;
  localparam int EV_LD  = 1;
  localparam int EV_HS  = 2;
  localparam int EV_FT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] hpos, vpos, pos_x, pos_y;
  logic       pos_wr, pos_en;
  logic       vstart, load, hstart, active, frame_tick;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int kind;
    int v;
    int h;
  } evt_t;

  typedef struct {
    int wr_line;
    int wr_x;
    int wr_y;
    bit wr_en;
    bit exp_valid;
    int exp_x;
    int exp_y;
    int win_lo;
    int rst_line;
  } frame_t;

  evt_t   exp_q[$];
  frame_t tbl[9];
  frame_t hand;

  sprite_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .pos_wr     (pos_wr),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_en     (pos_en),
    .vstart     (vstart),
    .load       (load),
    .hstart     (hstart),
    .active     (active),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic string kname(int k);
    case (k)
      EV_VST:  return "vstart";
      EV_LD:   return "load";
      EV_HS:   return "hstart";
      default: return "frame_tick";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic see(int kind);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got %s at line %0d hpos %0d, expected no pulse",
               kname(kind), vpos, hpos);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.v != int'(vpos) || e.h != int'(hpos)) begin
        errors++;
        $display("FAIL event_order: got %s at line %0d hpos %0d, expected %s at line %0d hpos %0d",
                 kname(kind), vpos, hpos, kname(e.kind), e.v, e.h);
      end
    end
    if (kind == EV_FT) check("active_low_at_tick", int'(active), 0);
    else               check("active_during_sprite", int'(active), 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (vstart)     see(EV_VST);
      if (load)       see(EV_LD);
      if (hstart)     see(EV_HS);
      if (frame_tick) see(EV_FT);
    end
  end

  task automatic push_evt(int kind, int v, int h, int rst_line);
    evt_t e;
    if (rst_line < 0 || v < rst_line) begin
      e.kind = kind;
      e.v    = v;
      e.h    = h;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_vstart"}, int'(vstart), 0);
    check({tag, "_load"}, int'(load), 0);
    check({tag, "_hstart"}, int'(hstart), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  // One frame: lines 0..240; lines near the sprite are full length, the rest are short.
  task automatic run_frame(frame_t f);
    int len;
    if (f.exp_valid) begin
      push_evt(EV_VST, f.exp_y, 1, f.rst_line);
      push_evt(EV_LD, f.exp_y, LD_SEEN, f.rst_line);
      for (int k = 1; k < 16; k++) begin
        push_evt(EV_HS, f.exp_y + k, f.exp_x + 1, f.rst_line);
        push_evt(EV_LD, f.exp_y + k, LD_SEEN, f.rst_line);
      end
      push_evt(EV_HS, f.exp_y + 16, f.exp_x + 1, f.rst_line);
    end
    push_evt(EV_FT, V_LAST, 1, -1);
    for (int v = 0; v <= V_LAST; v++) begin
      len = (v >= f.win_lo && v <= f.win_lo + 16) ? H_TOTAL : SHORT_LN;
      for (int h = 0; h < len; h++) begin
        if (v == f.rst_line && h == 0) begin
          rst_n = 1'b0;
          #1;
          check_outputs_zero("async_reset");
        end
        if (v == f.rst_line && h == 3) rst_n = 1'b1;
        hpos   = 9'(h);
        vpos   = 9'(v);
        pos_wr = (v == f.wr_line) && (h == 0);
        pos_x  = 9'(f.wr_x);
        pos_y  = 9'(f.wr_y);
        pos_en = f.wr_en;
        @(posedge clk);
        #1;
      end
    end
    pos_wr = 1'b0;
    check("frame_events_all_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{wr_line:5,   wr_x:100, wr_y:50,  wr_en:1, exp_valid:0, exp_x:0,   exp_y:0,
               win_lo:50,  rst_line:-1};
    tbl[1] = '{wr_line:55,  wr_x:100, wr_y:20,  wr_en:1, exp_valid:1, exp_x:100, exp_y:50,
               win_lo:50,  rst_line:-1};
    tbl[2] = '{wr_line:40,  wr_x:300, wr_y:10,  wr_en:1, exp_valid:1, exp_x:100, exp_y:20,
               win_lo:20,  rst_line:-1};
    tbl[3] = '{wr_line:40,  wr_x:5,   wr_y:230, wr_en:1, exp_valid:1, exp_x:240, exp_y:10,
               win_lo:10,  rst_line:-1};
    tbl[4] = '{wr_line:40,  wr_x:5,   wr_y:10,  wr_en:0, exp_valid:0, exp_x:0,   exp_y:0,
               win_lo:222, rst_line:-1};
    tbl[5] = '{wr_line:240, wr_x:8,   wr_y:0,   wr_en:1, exp_valid:0, exp_x:0,   exp_y:0,
               win_lo:10,  rst_line:-1};
    tbl[6] = '{wr_line:30,  wr_x:17,  wr_y:223, wr_en:1, exp_valid:1, exp_x:8,   exp_y:0,
               win_lo:0,   rst_line:-1};
    tbl[7] = '{wr_line:30,  wr_x:17,  wr_y:224, wr_en:1, exp_valid:1, exp_x:17,  exp_y:223,
               win_lo:223, rst_line:-1};
    tbl[8] = '{wr_line:30,  wr_x:100, wr_y:50,  wr_en:1, exp_valid:0, exp_x:0,   exp_y:0,
               win_lo:222, rst_line:-1};

    hpos   = '0;
    vpos   = '0;
    pos_wr = 1'b0;
    pos_x  = '0;
    pos_y  = '0;
    pos_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("after_reset_idle");
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) run_frame(tbl[i]);

    // Reset at line 58 of a live sprite, then recovery only after a new write and boundary.
    hand = '{wr_line:-1, wr_x:0, wr_y:0, wr_en:0, exp_valid:1, exp_x:100, exp_y:50,
             win_lo:50, rst_line:58};
    run_frame(hand);
    hand = '{wr_line:100, wr_x:100, wr_y:50, wr_en:1, exp_valid:0, exp_x:0, exp_y:0,
             win_lo:50, rst_line:-1};
    run_frame(hand);
    hand = '{wr_line:-1, wr_x:0, wr_y:0, wr_en:0, exp_valid:1, exp_x:100, exp_y:50,
             win_lo:50, rst_line:-1};
    run_frame(hand);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
